// File: rtl/adder_pkg.sv
// Shared constants and elaboration-time parameter check for the pipelined adder.
// Latency: none (package only).
// Backpressure: not applicable.
package adder_pkg;

  // Encoding of the sub input.
  localparam logic SUB_ADD = 1'b0;
  localparam logic SUB_SUB = 1'b1;

  // Legal geometry: at least 2 bits, 1..N stages, and the stages must split N evenly.
  function automatic bit chk_params(input int n, input int stages);
    return (n >= 2) && (stages >= 1) && (stages <= n) && ((n % stages) == 0);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit slice adder {co,s} = x + y + ci with signed overflow at the slice MSB.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline stage decides when the result is captured.
module add_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o,
  output logic         ovf_o
);

  // One extra bit of headroom captures the carry out of the slice.
  assign {co_o, s_o} = {1'b0, x_i} + {1'b0, y_i} + {{W{1'b0}}, ci_i};

  // Overflow only means something for the top slice, where the MSB is the sign bit.
  assign ovf_o = (x_i[W-1] == y_i[W-1]) && (s_o[W-1] != x_i[W-1]);

endmodule

// File: rtl/adder_nbit_pipe.sv
// Pipelined N-bit add/subtract with carry-in, carry-out and signed overflow, carry chain cut into STAGES slices.
// Latency: STAGES cycles from acceptance to out_valid; one beat per cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; when low the whole pipeline freezes, bubbles included.
module adder_nbit_pipe
  import adder_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CHUNK = (STAGES > 0) ? (N / STAGES) : 1;

  if (!chk_params(N, STAGES)) begin : g_bad_params
    $error("adder_nbit_pipe: N must be >= 2 and divisible by STAGES, with 1 <= STAGES <= N");
  end

  // One pipeline slot. Operands are already in effective form (b inverted for subtract),
  // so the subtract mode never has to travel past the first stage. Bits of a/b that a
  // slot no longer needs are left for synthesis to trim.
  typedef struct packed {
    logic         vld;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic         c;
    logic         ovf;
  } stage_t;

  stage_t st_q   [STAGES];
  stage_t st_d   [STAGES];
  stage_t st_src [STAGES];

  logic advance;

  assign advance  = !st_q[STAGES-1].vld || out_ready;
  assign in_ready = advance;

  // Stage 0 sees the raw inputs, folded into effective operand and carry-in.
  always_comb begin
    st_src[0]     = '0;
    st_src[0].vld = in_valid;
    st_src[0].a   = a;
    st_src[0].b   = (sub == SUB_SUB) ? ~b : b;
    st_src[0].c   = (sub == SUB_SUB) ? ~cin : cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] s_chunk;
    logic             co_chunk;
    logic             ovf_chunk;
    stage_t           nxt;

    if (k > 0) begin : g_chain
      assign st_src[k] = st_q[k-1];
    end

    add_chunk #(
      .W(CHUNK)
    ) u_add (
      .x_i   (st_src[k].a[k*CHUNK +: CHUNK]),
      .y_i   (st_src[k].b[k*CHUNK +: CHUNK]),
      .ci_i  (st_src[k].c),
      .s_o   (s_chunk),
      .co_o  (co_chunk),
      .ovf_o (ovf_chunk)
    );

    // Drop this slice's result into the travelling sum and hand the carry to the next stage.
    always_comb begin
      nxt                      = st_src[k];
      nxt.s[k*CHUNK +: CHUNK]  = s_chunk;
      nxt.c                    = co_chunk;
      nxt.ovf                  = ovf_chunk;
    end

    assign st_d[k] = nxt;
  end

  // Pipeline registers: cleared on reset, otherwise shift together or freeze together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        st_q[i] <= '0;
      end
    end else if (advance) begin
      for (int i = 0; i < STAGES; i++) begin
        st_q[i] <= st_d[i];
      end
    end
  end

  assign out_valid = st_q[STAGES-1].vld;
  assign sum       = st_q[STAGES-1].s;
  assign cout      = st_q[STAGES-1].c;
  assign ovf       = st_q[STAGES-1].ovf;

endmodule

// File: tb/tb_adder_nbit_pipe.sv
// Scoreboard bench for adder_nbit_pipe: four instances (STAGES = 1, 2, 4, 8) share one stimulus stream.
// Latency: expected beats are queued at acceptance and matched in order when each instance presents them.
// Backpressure: a single out_ready drives all instances; a beat is only offered when every instance is ready.
module tb_adder_nbit_pipe;

  localparam int NDUT = 4;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         acc;
    int         stall;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tb_vld = 1'b0;
  logic            out_rdy = 1'b1;
  logic [7:0]      a_r = '0;
  logic [7:0]      b_r = '0;
  logic            cin_r = 1'b0;
  logic            sub_r = 1'b0;
  logic            all_rdy;
  logic            dut_vld;
  logic [NDUT-1:0] ir, ov, co, of;
  logic [7:0]      sm [NDUT];

  exp_t expq [NDUT][$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  bit   held [NDUT];
  logic [7:0] hsum [NDUT];
  logic       hco  [NDUT];
  logic       hof  [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  assign all_rdy = &ir;
  assign dut_vld = tb_vld && all_rdy;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    adder_nbit_pipe #(
      .N(8),
      .STAGES(1 << g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (dut_vld),
      .in_ready  (ir[g]),
      .a         (a_r),
      .b         (b_r),
      .cin       (cin_r),
      .sub       (sub_r),
      .out_valid (ov[g]),
      .out_ready (out_rdy),
      .sum       (sm[g]),
      .cout      (co[g]),
      .ovf       (of[g])
    );
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s stages=%0d: got %0h, required %0h (t=%0t)", nm, 1 << k, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    exp_t e;
    int   ua, ub, u, sa, sb, r;
    logic [31:0] uv;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    if (!sub) begin
      u = ua + ub + cin;
      r = sa + sb + cin;
      e.cout = (u > 255);
    end else begin
      u = ua - ub - cin;
      r = sa - sb - cin;
      e.cout = (u >= 0);
    end
    uv = u;
    e.sum   = uv[7:0];
    e.ovf   = (r > 127) || (r < -128);
    e.acc   = 0;
    e.stall = 0;
    return e;
  endfunction

  // Monitor: pops and compares whenever an instance hands a beat downstream.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NDUT; k++) held[k] = 1'b0;
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        exp_t e;
        if (held[k]) begin
          chk("stall_valid", k, ov[k], 1);
          chk("stall_sum", k, sm[k], hsum[k]);
          chk("stall_flags", k, {co[k], of[k]}, {hco[k], hof[k]});
        end
        chk("in_ready", k, ir[k], !ov[k] || out_rdy);
        if (ov[k] && out_rdy) begin
          if (expq[k].size() == 0) begin
            chk("unexpected_out", k, 0, 1);
          end else begin
            e = expq[k].pop_front();
            chk("sum", k, sm[k], e.sum);
            chk("cout", k, co[k], e.cout);
            chk("ovf", k, of[k], e.ovf);
            if (e.stall == stall_cnt)
              chk("latency", k, cyc, e.acc + (1 << k) - 1);
            else
              chk("latency_min", k, (cyc >= e.acc + (1 << k) - 1), 1);
          end
        end
        held[k] = ov[k] && !out_rdy;
        hsum[k] = sm[k];
        hco[k]  = co[k];
        hof[k]  = of[k];
      end
    end
  end

  task automatic step(output bit acc);
    @(negedge clk);
    acc = !rst && tb_vld && all_rdy;
    if (!out_rdy) stall_cnt++;
    if (acc) begin
      for (int k = 0; k < NDUT; k++) begin
        exp_t e;
        e = model(a_r, b_r, cin_r, sub_r);
        e.acc   = cyc + 1;
        e.stall = stall_cnt;
        expq[k].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    tb_vld = 1'b0;
    repeat (n) step(acc);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    bit acc;
    a_r = a; b_r = b; cin_r = cin; sub_r = sub;
    tb_vld = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) step(acc);
    if (!acc) chk("accept_timeout", 0, 0, 1);
    tb_vld = 1'b0;
  endtask

  task automatic send_rand();
    send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic check_idle_state();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_out_valid", k, ov[k], 0);
      chk("rst_sum", k, sm[k], 0);
      chk("rst_flags", k, {co[k], of[k]}, 0);
      chk("rst_in_ready", k, ir[k], 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    int pending;
    out_rdy = 1'b1;
    tb_vld  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      pending = 0;
      for (int k = 0; k < NDUT; k++) pending += expq[k].size();
      if (pending == 0) break;
      step(acc);
    end
    for (int k = 0; k < NDUT; k++) chk("drain_empty", k, expq[k].size(), 0);
  endtask

  initial begin
    bit acc;
    int n;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_idle_state();

    // Directed corners, streamed back to back.
    send(8'h0F, 8'h01, 1'b0, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    send(8'h05, 8'h07, 1'b0, 1'b1);
    send(8'h80, 8'h01, 1'b0, 1'b1);
    send(8'hFF, 8'h00, 1'b1, 1'b0);
    send(8'h00, 8'h00, 1'b1, 1'b1);
    drain();

    // Backpressure: three stalled cycles inside a five-beat stream, offer pending during stall.
    send_rand();
    send_rand();
    out_rdy = 1'b0;
    a_r = 8'($urandom); b_r = 8'($urandom);
    tb_vld = 1'b1;
    repeat (3) step(acc);
    out_rdy = 1'b1;
    tb_vld = 1'b0;
    send_rand();
    send_rand();
    send_rand();
    drain();

    // Reset mid-operation, with a handshake offered on the reset edge.
    send_rand();
    send_rand();
    rst = 1'b1;
    tb_vld = 1'b1;
    step(acc);
    rst = 1'b0;
    tb_vld = 1'b0;
    for (int k = 0; k < NDUT; k++) expq[k].delete();
    check_idle_state();
    idle(8);
    send(8'h01, 8'h02, 1'b0, 1'b0);
    drain();

    // Random traffic with random bubbles and backpressure.
    n = 0;
    for (int i = 0; i < 10000 && n < 1000; i++) begin
      tb_vld  = ($urandom_range(0, 4) != 0);
      a_r     = 8'($urandom);
      b_r     = 8'($urandom);
      cin_r   = 1'($urandom);
      sub_r   = 1'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) n++;
    end
    chk("random_beats", 0, n, 1000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
